alu_param: RTL and testbench
============================

# alu_param

Parametrised, registered ALU: the successor to the fixed-width ALU used by the current regression environment. Adds a generic operand width, a two-cycle multiply path with a BUSY indication, an operand-collection FSM that accepts A and B on different cycles with a timeout, and an explicit OUT_VALID strobe. It sits between the driver interface and the scoreboard/reference model and keeps the same flag set (G/L/E/ERR/COUT/OFLOW).

## Interface
- WIDTH, 8: operand width, ≥4, power of two
- CMD_W, 4: command field width
- TIMEOUT, 16: cycles to wait for a missing second operand
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable; 0 freezes all state and outputs
- MODE  in  1  1 = arithmetic, 0 = logic
- CMD  in  CMD_W  operation select
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- OPA, OPB  in  WIDTH  operands
- CIN  in  1  carry-in for ADD_CIN/SUB_CIN
- RES  out  2*WIDTH  result, zero-extended unless stated
- COUT  out  1  carry/borrow out
- OFLOW  out  1  signed overflow (SADD/SSUB), unsigned underflow (SUB/DEC)
- G, L, E  out  1  CMP flags (unsigned)
- ERR  out  1  illegal CMD, bad rotate amount, or operand timeout
- OUT_VALID  out  1  one-cycle strobe: outputs carry a new result
- BUSY  out  1  multiply in flight; inputs ignored

## Operation
- Arithmetic (MODE=1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 MUL_INC ((A+1)*(B+1)), 10 MUL_SHL ((A<<1 mod 2^WIDTH)*B), 11 SADD, 12 SSUB (signed, result sign-extended to 2*WIDTH).
- Logic (MODE=0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B. Results are WIDTH bits, upper half zero.
- Unlisted CMD: ERR=1, RES=0, OUT_VALID=1.
- Rotate: amount = OPB[log2(WIDTH)-1:0]; any higher OPB bit set → ERR=1 with rotated result still driven.
- Single-operand ops (INC/DEC/NOT/shift) need only their operand's INP_VALID bit; the other bit is ignored.
- Flags not defined for an op are 0. COUT = bit WIDTH of ADD family; borrow for SUB family.
- FSM states: IDLE, WAIT_A, WAIT_B, MUL.
  - IDLE, two-operand op, INP_VALID=11 → execute. INP_VALID=01 → latch OPA, CMD, MODE, go WAIT_B. 10 → latch OPB, go WAIT_A. 00 → stay, OUT_VALID=0, outputs hold.
  - WAIT_x: wait counter increments each CE cycle; the missing bit arriving → execute with latched CMD/MODE (new CMD ignored). Counter reaching TIMEOUT with no operand → ERR=1, RES=0, OUT_VALID=1, back to IDLE.
  - Multiply → MUL for one cycle, BUSY=1, then IDLE.

## Timing
- Inputs sampled at edge k. Non-multiply results, flags, OUT_VALID update at edge k (visible after k). Multiply: BUSY high after edge k, result + OUT_VALID after edge k+1; inputs during BUSY dropped.
- Timeout: operand arrives at edge k; ERR asserted at edge k+TIMEOUT if the second never arrives; arrival at edge k+TIMEOUT-1 still succeeds.
- OUT_VALID is a one-cycle pulse; RES/flags hold until the next result.
- CE=0: no state, counter, or output changes; OUT_VALID held 0 for that cycle; resumes exactly where it stopped.
- RST (wins over CE, any state incl. MUL/WAIT): at the next edge all outputs 0, FSM IDLE, counter 0, latched operands cleared.

## Structure
- Package alu_param_pkg: mode/CMD enums for both modes, FSM state enum, default TIMEOUT constant.
- One sub-module alu_param_core: combinational result/flag computation from (mode, cmd, a, b, cin), excluding multiply pipelining; top holds FSM, operand latches, multiply register, output regs.

## Test plan
- WIDTH=8, MODE=1 CMD=0, A=8'hFF B=8'h01 IV=11 → RES=9'h100, COUT=1, OUT_VALID one cycle.
- MUL_INC A=3 B=4 → BUSY 1 cycle, RES=20 one edge later; input applied during BUSY produces no result.
- IV=01 A=5 CMD ADD, 3 idle cycles, IV=10 B=7 → RES=12; repeat with no B for 16 cycles → ERR=1, RES=0.
- ROL A=8'h81 B=1 → RES=8'h03, ERR=0; B=8'h11 → RES=8'h03, ERR=1; CMD=15 → ERR=1.
- SADD 8'h7F+8'h01 → OFLOW=1, RES=16'hFF80; CMP A=5 B=9 → L=1, G=E=0.
- RST during MUL and during WAIT_B → all outputs 0 next edge; CE=0 for 4 cycles mid-WAIT does not advance timeout.

Source files
------------

// File: rtl/alu_param_pkg.sv
// Shared types for the parametrised ALU: mode/command encodings, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_param_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    MODE_LOGIC = 1'b0,
    MODE_ARITH = 1'b1
  } mode_e;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10,
    A_SADD    = 4'd11,
    A_SSUB    = 4'd12
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_MUL    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_param_core.sv
// Combinational result/flag datapath for every ALU op, plus operand-need and multiply classification.
// Latency: 0 cycles (purely combinational; the top registers everything).
// Backpressure: none; the top decides when the outputs are captured.
module alu_param_core
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CMD_W = 4
) (
  input  logic               mode,
  input  logic [CMD_W-1:0]   cmd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               g,
  output logic               l,
  output logic               e,
  output logic               err,
  output logic               illegal,
  output logic               need_a,
  output logic               need_b,
  output logic               is_mul
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE_W1 = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [3:0]         cmd_lo;
  logic               cmd_hi;
  logic [WIDTH:0]     add_s, addc_s, sub_d, subc_d, inc_a_s, inc_b_s;
  logic [WIDTH-1:0]   dec_a_s, dec_b_s, sadd_s, ssub_s, a_shl, rol_s, ror_s;
  logic [2*WIDTH-1:0] rol_w, ror_w, mul_inc_p, mul_shl_p;
  logic [SH_W-1:0]    amt;
  logic               sadd_ov, ssub_ov, rot_bad;

  assign cmd_lo = cmd[3:0];

  // Command bits above the 4-bit opcode space always decode as illegal.
  if (CMD_W > 4) begin : g_cmd_hi
    assign cmd_hi = |cmd[CMD_W-1:4];
  end else begin : g_no_cmd_hi
    assign cmd_hi = 1'b0;
  end

  // Unsigned add/sub keep one extra bit: carry for adds, borrow (sign) for subtracts.
  assign add_s   = {1'b0, a} + {1'b0, b};
  assign addc_s  = add_s + {{WIDTH{1'b0}}, cin};
  assign sub_d   = {1'b0, a} - {1'b0, b};
  assign subc_d  = sub_d - {{WIDTH{1'b0}}, cin};
  assign inc_a_s = {1'b0, a} + ONE_W1;
  assign inc_b_s = {1'b0, b} + ONE_W1;
  assign dec_a_s = a - ONE_W;
  assign dec_b_s = b - ONE_W;

  assign sadd_s  = a + b;
  assign ssub_s  = a - b;
  assign sadd_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sadd_s[WIDTH-1] != a[WIDTH-1]);
  assign ssub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (ssub_s[WIDTH-1] != a[WIDTH-1]);

  // Rotates via a doubled operand; only the low log2(WIDTH) bits of b are the amount.
  assign amt     = b[SH_W-1:0];
  assign rot_bad = (b >> SH_W) != '0;
  assign rol_w   = {a, a} << amt;
  assign ror_w   = {a, a} >> amt;
  assign rol_s   = rol_w[2*WIDTH-1:WIDTH];
  assign ror_s   = ror_w[WIDTH-1:0];

  // Products truncated to 2*WIDTH; (A+1)*(B+1) can exceed that only at the extreme corner.
  assign a_shl     = {a[WIDTH-2:0], 1'b0};
  assign mul_inc_p = {{(WIDTH-1){1'b0}}, inc_a_s} * {{(WIDTH-1){1'b0}}, inc_b_s};
  assign mul_shl_p = {{WIDTH{1'b0}}, a_shl} * {{WIDTH{1'b0}}, b};

  // Decode mode/cmd into result, flags and operand requirements.
  always_comb begin
    res     = '0;
    cout    = 1'b0;
    oflow   = 1'b0;
    g       = 1'b0;
    l       = 1'b0;
    e       = 1'b0;
    err     = 1'b0;
    illegal = 1'b0;
    need_a  = 1'b1;
    need_b  = 1'b1;
    is_mul  = 1'b0;
    if (cmd_hi) begin
      illegal = 1'b1;
      err     = 1'b1;
    end else if (mode == MODE_ARITH) begin
      case (cmd_lo)
        A_ADD:     begin res = {{(WIDTH-1){1'b0}}, add_s};  cout = add_s[WIDTH]; end
        A_SUB:     begin res = {{WIDTH{1'b0}}, sub_d[WIDTH-1:0]}; cout = sub_d[WIDTH]; oflow = sub_d[WIDTH]; end
        A_ADD_CIN: begin res = {{(WIDTH-1){1'b0}}, addc_s}; cout = addc_s[WIDTH]; end
        A_SUB_CIN: begin res = {{WIDTH{1'b0}}, subc_d[WIDTH-1:0]}; cout = subc_d[WIDTH]; end
        A_INC_A:   begin res = {{(WIDTH-1){1'b0}}, inc_a_s}; need_b = 1'b0; end
        A_DEC_A:   begin res = {{WIDTH{1'b0}}, dec_a_s}; oflow = (a == '0); need_b = 1'b0; end
        A_INC_B:   begin res = {{(WIDTH-1){1'b0}}, inc_b_s}; need_a = 1'b0; end
        A_DEC_B:   begin res = {{WIDTH{1'b0}}, dec_b_s}; oflow = (b == '0); need_a = 1'b0; end
        A_CMP:     begin g = (a > b); l = (a < b); e = (a == b); end
        A_MUL_INC: begin res = mul_inc_p; is_mul = 1'b1; end
        A_MUL_SHL: begin res = mul_shl_p; is_mul = 1'b1; end
        A_SADD:    begin res = {{WIDTH{sadd_s[WIDTH-1]}}, sadd_s}; oflow = sadd_ov; end
        A_SSUB:    begin res = {{WIDTH{ssub_s[WIDTH-1]}}, ssub_s}; oflow = ssub_ov; end
        default:   begin illegal = 1'b1; err = 1'b1; end
      endcase
    end else begin
      case (cmd_lo)
        L_AND:     res = {{WIDTH{1'b0}}, a & b};
        L_NAND:    res = {{WIDTH{1'b0}}, ~(a & b)};
        L_OR:      res = {{WIDTH{1'b0}}, a | b};
        L_NOR:     res = {{WIDTH{1'b0}}, ~(a | b)};
        L_XOR:     res = {{WIDTH{1'b0}}, a ^ b};
        L_XNOR:    res = {{WIDTH{1'b0}}, ~(a ^ b)};
        L_NOT_A:   begin res = {{WIDTH{1'b0}}, ~a}; need_b = 1'b0; end
        L_NOT_B:   begin res = {{WIDTH{1'b0}}, ~b}; need_a = 1'b0; end
        L_SHR1_A:  begin res = {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]}; need_b = 1'b0; end
        L_SHL1_A:  begin res = {{WIDTH{1'b0}}, a_shl}; need_b = 1'b0; end
        L_SHR1_B:  begin res = {{WIDTH{1'b0}}, 1'b0, b[WIDTH-1:1]}; need_a = 1'b0; end
        L_SHL1_B:  begin res = {{WIDTH{1'b0}}, b[WIDTH-2:0], 1'b0}; need_a = 1'b0; end
        L_ROL_A_B: begin res = {{WIDTH{1'b0}}, rol_s}; err = rot_bad; end
        L_ROR_A_B: begin res = {{WIDTH{1'b0}}, ror_s}; err = rot_bad; end
        default:   begin illegal = 1'b1; err = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/alu_param.sv
// Registered ALU with split-cycle operand collection, operand timeout and a two-cycle multiply.
// Latency: 1 edge for non-multiply results, 2 edges for multiply (BUSY high in between).
// Backpressure: none; inputs presented while BUSY or with CE=0 are dropped, not stalled.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               MODE,
  input  logic [CMD_W-1:0]   CMD,
  input  logic [1:0]         INP_VALID,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic               CIN,
  output logic [2*WIDTH-1:0] RES,
  output logic               COUT,
  output logic               OFLOW,
  output logic               G,
  output logic               L,
  output logic               E,
  output logic               ERR,
  output logic               OUT_VALID,
  output logic               BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               lat_mode;
  logic [CMD_W-1:0]   lat_cmd;
  logic [WIDTH-1:0]   lat_a, lat_b;

  logic               c_mode;
  logic [CMD_W-1:0]   c_cmd;
  logic [WIDTH-1:0]   c_a, c_b;

  logic [2*WIDTH-1:0] k_res;
  logic               k_cout, k_oflow, k_g, k_l, k_e, k_err;
  logic               k_illegal, k_need_a, k_need_b, k_is_mul;

  logic               go, fire, start_mul, timeout, cnt_inc, lat_a_en, lat_b_en;

  alu_param_core #(
    .WIDTH (WIDTH),
    .CMD_W (CMD_W)
  ) u_core (
    .mode    (c_mode),
    .cmd     (c_cmd),
    .a       (c_a),
    .b       (c_b),
    .cin     (CIN),
    .res     (k_res),
    .cout    (k_cout),
    .oflow   (k_oflow),
    .g       (k_g),
    .l       (k_l),
    .e       (k_e),
    .err     (k_err),
    .illegal (k_illegal),
    .need_a  (k_need_a),
    .need_b  (k_need_b),
    .is_mul  (k_is_mul)
  );

  // Pick core operands per state and decide whether this edge executes, waits, times out or starts a multiply.
  always_comb begin
    c_mode    = lat_mode;
    c_cmd     = lat_cmd;
    c_a       = lat_a;
    c_b       = lat_b;
    state_nx  = state;
    go        = 1'b0;
    fire      = 1'b0;
    start_mul = 1'b0;
    timeout   = 1'b0;
    cnt_inc   = 1'b0;
    lat_a_en  = 1'b0;
    lat_b_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        c_mode = MODE;
        c_cmd  = CMD;
        c_a    = OPA;
        c_b    = OPB;
        if (k_illegal) begin
          fire = |INP_VALID;
        end else if (k_need_a && k_need_b) begin
          case (INP_VALID)
            2'b11: go = 1'b1;
            2'b01: begin lat_a_en = 1'b1; state_nx = ST_WAIT_B; end
            2'b10: begin lat_b_en = 1'b1; state_nx = ST_WAIT_A; end
            default: ;
          endcase
        end else begin
          go = (k_need_a && INP_VALID[0]) || (k_need_b && INP_VALID[1]);
        end
      end
      ST_WAIT_B: begin
        c_b = OPB;
        if (INP_VALID[1]) begin
          go = 1'b1;
        end else if (cnt == CNT_LAST) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_A: begin
        c_a = OPA;
        if (INP_VALID[0]) begin
          go = 1'b1;
        end else if (cnt == CNT_LAST) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_MUL: begin
        fire     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // Multiplies capture both operands and spend one cycle in MUL; everything else registers now.
    if (go) begin
      if (k_is_mul) begin
        start_mul = 1'b1;
        lat_a_en  = 1'b1;
        lat_b_en  = 1'b1;
        state_nx  = ST_MUL;
      end else begin
        fire     = 1'b1;
        state_nx = ST_IDLE;
      end
    end
  end

  // FSM, timeout counter, operand latches and output registers; CE=0 freezes all but the valid strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_mode  <= 1'b0;
      lat_cmd   <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      RES       <= '0;
      COUT      <= 1'b0;
      OFLOW     <= 1'b0;
      G         <= 1'b0;
      L         <= 1'b0;
      E         <= 1'b0;
      ERR       <= 1'b0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else if (CE) begin
      state     <= state_nx;
      cnt       <= cnt_inc ? cnt + CNT_ONE : '0;
      OUT_VALID <= fire | timeout;
      BUSY      <= start_mul;
      if (lat_a_en) lat_a <= c_a;
      if (lat_b_en) lat_b <= c_b;
      if (lat_a_en || lat_b_en) begin
        lat_mode <= c_mode;
        lat_cmd  <= c_cmd;
      end
      if (fire) begin
        RES   <= k_res;
        COUT  <= k_cout;
        OFLOW <= k_oflow;
        G     <= k_g;
        L     <= k_l;
        E     <= k_e;
        ERR   <= k_err;
      end else if (timeout) begin
        RES   <= '0;
        COUT  <= 1'b0;
        OFLOW <= 1'b0;
        G     <= 1'b0;
        L     <= 1'b0;
        E     <= 1'b0;
        ERR   <= 1'b1;
      end
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_param.sv
// Directed bench for alu_param: vector table for single-cycle ops plus hand sequences for multi-cycle cases.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_alu_param;
  import alu_param_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, CE, MODE, CIN;
  logic [3:0]  CMD;
  logic [1:0]  INP_VALID;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        COUT, OFLOW, G, L, E, ERR, OUT_VALID, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        mode;
    logic [3:0]  cmd;
    logic [1:0]  iv;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [15:0] res;
    logic [5:0]  flg;   // {COUT, OFLOW, G, L, E, ERR}
  } vec_t;

  vec_t vt[$];

  alu_param #(.WIDTH(8), .CMD_W(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
    .G(G), .L(L), .E(E), .ERR(ERR), .OUT_VALID(OUT_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic m, input logic [3:0] c, input logic [1:0] iv,
                              input logic [7:0] a, input logic [7:0] b, input logic ci,
                              input logic [15:0] r, input logic [5:0] f);
    vec_t v;
    v.mode = m; v.cmd = c; v.iv = iv; v.a = a; v.b = b; v.cin = ci; v.res = r; v.flg = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                       input logic [7:0] a, input logic [7:0] b, input logic ci);
    MODE = m; CMD = c; INP_VALID = iv; OPA = a; OPB = b; CIN = ci;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " res"}, RES, 16'h0000);
    chk({nm, " flags"}, 16'({COUT, OFLOW, G, L, E, ERR, OUT_VALID, BUSY}), 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CE = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    step(); step();
    chk_zero("reset");
    RST = 1'b0;

    // Arithmetic
    vt.push_back(mk(1, A_ADD,     2'b11, 8'hFF, 8'h01, 0, 16'h0100, 6'b100000));
    vt.push_back(mk(1, A_SUB,     2'b11, 8'h05, 8'h09, 0, 16'h00FC, 6'b110000));
    vt.push_back(mk(1, A_ADD_CIN, 2'b11, 8'h10, 8'h20, 1, 16'h0031, 6'b000000));
    vt.push_back(mk(1, A_SUB_CIN, 2'b11, 8'h10, 8'h05, 1, 16'h000A, 6'b000000));
    vt.push_back(mk(1, A_INC_A,   2'b01, 8'h41, 8'hEE, 0, 16'h0042, 6'b000000));
    vt.push_back(mk(1, A_DEC_A,   2'b01, 8'h00, 8'hEE, 0, 16'h00FF, 6'b010000));
    vt.push_back(mk(1, A_INC_B,   2'b10, 8'hEE, 8'h0F, 0, 16'h0010, 6'b000000));
    vt.push_back(mk(1, A_DEC_B,   2'b10, 8'hEE, 8'h10, 0, 16'h000F, 6'b000000));
    vt.push_back(mk(1, A_CMP,     2'b11, 8'h05, 8'h09, 0, 16'h0000, 6'b000100));
    vt.push_back(mk(1, A_CMP,     2'b11, 8'h09, 8'h09, 0, 16'h0000, 6'b000010));
    vt.push_back(mk(1, A_CMP,     2'b11, 8'hA0, 8'h09, 0, 16'h0000, 6'b001000));
    vt.push_back(mk(1, A_SADD,    2'b11, 8'h7F, 8'h01, 0, 16'hFF80, 6'b010000));
    vt.push_back(mk(1, A_SSUB,    2'b11, 8'h80, 8'h01, 0, 16'h007F, 6'b010000));
    vt.push_back(mk(1, A_SSUB,    2'b11, 8'h05, 8'h07, 0, 16'hFFFE, 6'b000000));
    vt.push_back(mk(1, 4'd15,     2'b11, 8'h12, 8'h34, 0, 16'h0000, 6'b000001));
    // Logic
    vt.push_back(mk(0, L_AND,     2'b11, 8'hF0, 8'h3C, 0, 16'h0030, 6'b000000));
    vt.push_back(mk(0, L_NAND,    2'b11, 8'hF0, 8'h3C, 0, 16'h00CF, 6'b000000));
    vt.push_back(mk(0, L_OR,      2'b11, 8'hF0, 8'h3C, 0, 16'h00FC, 6'b000000));
    vt.push_back(mk(0, L_NOR,     2'b11, 8'hF0, 8'h3C, 0, 16'h0003, 6'b000000));
    vt.push_back(mk(0, L_XOR,     2'b11, 8'hF0, 8'h3C, 0, 16'h00CC, 6'b000000));
    vt.push_back(mk(0, L_XNOR,    2'b11, 8'hF0, 8'h3C, 0, 16'h0033, 6'b000000));
    vt.push_back(mk(0, L_NOT_A,   2'b01, 8'hF0, 8'h3C, 0, 16'h000F, 6'b000000));
    vt.push_back(mk(0, L_NOT_B,   2'b10, 8'hF0, 8'h3C, 0, 16'h00C3, 6'b000000));
    vt.push_back(mk(0, L_SHR1_A,  2'b01, 8'h81, 8'h00, 0, 16'h0040, 6'b000000));
    vt.push_back(mk(0, L_SHL1_A,  2'b01, 8'h81, 8'h00, 0, 16'h0002, 6'b000000));
    vt.push_back(mk(0, L_SHR1_B,  2'b10, 8'h00, 8'h81, 0, 16'h0040, 6'b000000));
    vt.push_back(mk(0, L_SHL1_B,  2'b10, 8'h00, 8'hC3, 0, 16'h0086, 6'b000000));
    vt.push_back(mk(0, L_ROL_A_B, 2'b11, 8'h81, 8'h01, 0, 16'h0003, 6'b000000));
    vt.push_back(mk(0, L_ROL_A_B, 2'b11, 8'h81, 8'h11, 0, 16'h0003, 6'b000001));
    vt.push_back(mk(0, L_ROR_A_B, 2'b11, 8'h81, 8'h01, 0, 16'h00C0, 6'b000000));
    vt.push_back(mk(0, L_ROR_A_B, 2'b11, 8'h12, 8'h04, 0, 16'h0021, 6'b000000));
    vt.push_back(mk(0, 4'd14,     2'b11, 8'h12, 8'h34, 0, 16'h0000, 6'b000001));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].mode, vt[i].cmd, vt[i].iv, vt[i].a, vt[i].b, vt[i].cin);
      step();
      chk($sformatf("vec%0d res", i), RES, vt[i].res);
      chk($sformatf("vec%0d flags", i), 16'({COUT, OFLOW, G, L, E, ERR}), 16'(vt[i].flg));
      chk($sformatf("vec%0d out_valid", i), 16'(OUT_VALID), 16'h0001);
    end

    // OUT_VALID is a single pulse and RES holds; single-operand op without its bit does nothing
    drive(1, A_ADD, 2'b11, 8'hFF, 8'h01, 0);
    step();
    chk("pulse res", RES, 16'h0100);
    chk("pulse valid", 16'(OUT_VALID), 16'h0001);
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    step();
    chk("pulse drop", 16'(OUT_VALID), 16'h0000);
    chk("pulse hold", RES, 16'h0100);
    drive(1, A_INC_A, 2'b10, 8'h11, 8'h22, 0);
    step();
    chk("inc_a no a", 16'(OUT_VALID), 16'h0000);

    // Multiply: BUSY for one cycle, input during BUSY is dropped
    drive(1, A_MUL_INC, 2'b11, 8'h03, 8'h04, 0);
    step();
    chk("mul busy", 16'(BUSY), 16'h0001);
    chk("mul no valid yet", 16'(OUT_VALID), 16'h0000);
    drive(1, A_ADD, 2'b11, 8'h01, 8'h01, 0);
    step();
    chk("mul busy clr", 16'(BUSY), 16'h0000);
    chk("mul valid", 16'(OUT_VALID), 16'h0001);
    chk("mul_inc res", RES, 16'h0014);
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    step();
    chk("busy input dropped", 16'(OUT_VALID), 16'h0000);
    chk("busy input res", RES, 16'h0014);
    drive(1, A_MUL_SHL, 2'b11, 8'h40, 8'h10, 0);
    step();
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    step();
    chk("mul_shl res", RES, 16'h0800);

    // Split operands: A then B three idle cycles later; CMD change while waiting is ignored
    drive(1, A_ADD, 2'b01, 8'h05, 8'hAA, 0);
    step();
    chk("split wait valid", 16'(OUT_VALID), 16'h0000);
    drive(1, A_SUB, 2'b00, 8'h33, 8'h44, 0);
    step(); step(); step();
    drive(1, A_SUB, 2'b10, 8'h99, 8'h07, 0);
    step();
    chk("split res", RES, 16'h000C);
    chk("split valid", 16'(OUT_VALID), 16'h0001);

    // Timeout: no B for 16 cycles
    drive(1, A_ADD, 2'b01, 8'h05, 8'h00, 0);
    step();
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("tmo quiet %0d", i), 16'(OUT_VALID), 16'h0000);
    end
    step();
    chk("tmo err", 16'(ERR), 16'h0001);
    chk("tmo res", RES, 16'h0000);
    chk("tmo valid", 16'(OUT_VALID), 16'h0001);

    // Arrival on the last cycle before timeout still succeeds
    drive(1, A_ADD, 2'b01, 8'h05, 8'h00, 0);
    step();
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 1; i < 15; i++) step();
    drive(1, A_ADD, 2'b10, 8'h00, 8'h07, 0);
    step();
    chk("late res", RES, 16'h000C);
    chk("late err", 16'(ERR), 16'h0000);
    chk("late valid", 16'(OUT_VALID), 16'h0001);

    // CE=0 for 4 cycles mid-wait: counter and operand capture frozen
    drive(1, A_ADD, 2'b01, 8'h05, 8'h00, 0);
    step();
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) step();
    CE = 1'b0;
    drive(1, A_ADD, 2'b10, 8'h00, 8'h07, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ce0 valid %0d", i), 16'(OUT_VALID), 16'h0000);
    end
    CE = 1'b1;
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ce resume valid %0d", i), 16'(OUT_VALID), 16'h0000);
    end
    chk("ce resume err", 16'(ERR), 16'h0000);
    step();
    chk("ce tmo err", 16'(ERR), 16'h0001);
    chk("ce tmo valid", 16'(OUT_VALID), 16'h0001);

    // Reset during MUL
    drive(1, A_ADD, 2'b11, 8'hFF, 8'h01, 0);
    step();
    drive(1, A_MUL_INC, 2'b11, 8'h03, 8'h04, 0);
    step();
    chk("pre-rst busy", 16'(BUSY), 16'h0001);
    RST = 1'b1;
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    step();
    chk_zero("rst in mul");
    RST = 1'b0;
    drive(1, A_ADD, 2'b11, 8'h01, 8'h02, 0);
    step();
    chk("post-rst add", RES, 16'h0003);
    chk("post-rst valid", 16'(OUT_VALID), 16'h0001);

    // Reset during WAIT_B: afterwards a lone B must start a fresh wait, not complete
    drive(1, A_ADD, 2'b01, 8'h05, 8'h00, 0);
    step();
    RST = 1'b1;
    drive(1, A_ADD, 2'b00, 8'h00, 8'h00, 0);
    step();
    chk_zero("rst in wait");
    RST = 1'b0;
    drive(1, A_ADD, 2'b10, 8'h00, 8'h07, 0);
    step();
    chk("post-rst lone b", 16'(OUT_VALID), 16'h0000);
    drive(1, A_ADD, 2'b01, 8'h01, 8'h00, 0);
    step();
    chk("post-rst wait_a res", RES, 16'h0008);
    chk("post-rst wait_a valid", 16'(OUT_VALID), 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
